// File: rtl/tdp_ram_pkg.sv
// tdp_ram_pkg: shared types and constants for the tdp_ram true dual-port RAM.
//   tdp_state_t   : clear-sequencer state encoding (REARM is reserved, behaves as CLEAR)
//   READ_LAT_BASE : read latency of the RAM read register alone
//   PRIO_A        : 1 = port A wins a same-address write/write collision
package tdp_ram_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'b00,
    RUN   = 2'b01,
    REARM = 2'b10
  } tdp_state_t;

  localparam int unsigned READ_LAT_BASE = 1;

  localparam bit PRIO_A = 1'b1;

endpackage

// File: rtl/tdp_ram_port.sv
// tdp_ram_port: read-side pipeline for one tdp_ram port.
// Holds the RAM read register, the optional output stage (TDP_RAM_OUT_REG_EN)
// and rvalid generation. rdata and rvalid advance together; rdata holds
// whenever no new read reaches a stage.
//   clk, rst_n : clock, asynchronous active-low reset
//   rd_req     : accepted read request this cycle
//   rd_word    : current contents of the addressed word (read-first)
//   rdata      : read data output
//   rvalid     : one-cycle strobe, rdata carries new read data
module tdp_ram_port
  import tdp_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [DATA_W-1:0] rd_word,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid
);

`ifdef TDP_RAM_OUT_REG_EN
  localparam int unsigned STAGES = READ_LAT_BASE + 1;
`else
  localparam int unsigned STAGES = READ_LAT_BASE;
`endif

  logic [DATA_W-1:0] data_q [STAGES];
  logic [STAGES-1:0] valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++) data_q[i] <= '0;
      valid_q <= '0;
    end else begin
      valid_q[0] <= rd_req;
      if (rd_req) data_q[0] <= rd_word;
      for (int unsigned i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        if (valid_q[i-1]) data_q[i] <= data_q[i-1];
      end
    end
  end

  assign rdata  = data_q[STAGES-1];
  assign rvalid = valid_q[STAGES-1];

endmodule

// File: rtl/tdp_ram.sv
// tdp_ram: parametrised true dual-port synchronous RAM with post-reset clear.
// After reset a sequencer writes CLEAR_VAL to every word (init_busy high,
// port requests dropped), then both ports run independently. Reads are
// read-first; on a same-address double write port A wins and wr_coll pulses.
// Optional macro TDP_RAM_OUT_REG_EN adds one output register stage per port.
//   clk, rst_n                 : clock, asynchronous active-low reset
//   init_busy                  : clear sequencer running
//   a_en/a_we/a_addr/a_wdata   : port A request
//   a_rdata/a_rvalid           : port A read data / strobe
//   b_*                        : same for port B
//   wr_coll                    : registered write/write collision strobe
module tdp_ram
  import tdp_ram_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       ADDR_W    = 4,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              wr_coll
);

  localparam int unsigned       DEPTH     = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  tdp_state_t        state, state_next;
  logic [ADDR_W-1:0] cnt, cnt_next;
  logic              clear_we;
  logic              run;

  logic [DATA_W-1:0] mem [DEPTH];

  logic a_wr, b_wr, coll, a_wr_ok, b_wr_ok;
  logic a_rd, b_rd;

  // Clear sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    clear_we   = 1'b0;
    case (state)
      RUN: ;
      default: begin
        // CLEAR, and the reserved REARM encoding treated as CLEAR
        clear_we   = 1'b1;
        cnt_next   = cnt + 1'b1;
        state_next = (cnt == LAST_ADDR) ? RUN : CLEAR;
      end
    endcase
  end

  assign run       = (state == RUN);
  assign init_busy = ~run;

  // Write arbitration
  assign a_wr    = run & a_en & a_we;
  assign b_wr    = run & b_en & b_we;
  assign coll    = a_wr & b_wr & (a_addr == b_addr);
  assign a_wr_ok = a_wr & (PRIO_A | ~coll);
  assign b_wr_ok = b_wr & (~PRIO_A | ~coll);

  assign a_rd = run & a_en & ~a_we;
  assign b_rd = run & b_en & ~b_we;

  // Memory array: no reset, the clear sequencer initialises it
  always_ff @(posedge clk) begin
    if (clear_we) mem[cnt]    <= CLEAR_VAL;
    if (a_wr_ok)  mem[a_addr] <= a_wdata;
    if (b_wr_ok)  mem[b_addr] <= b_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wr_coll <= 1'b0;
    else        wr_coll <= coll;
  end

  // Reads sample the array before this edge's writes land, giving read-first
  tdp_ram_port #(.DATA_W(DATA_W)) u_port_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_req  (a_rd),
    .rd_word (mem[a_addr]),
    .rdata   (a_rdata),
    .rvalid  (a_rvalid)
  );

  tdp_ram_port #(.DATA_W(DATA_W)) u_port_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_req  (b_rd),
    .rd_word (mem[b_addr]),
    .rdata   (b_rdata),
    .rvalid  (b_rvalid)
  );

endmodule

// File: tb/tb_tdp_ram.sv
// tb_tdp_ram: directed self-checking bench for tdp_ram (8-bit x 16, CLEAR_VAL 8'h5A).
module tb_tdp_ram;

`ifdef TDP_RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       init_busy;
  logic       a_en, a_we, b_en, b_we;
  logic [3:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic       a_rvalid, b_rvalid, wr_coll;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tdp_ram #(.DATA_W(8), .ADDR_W(4), .CLEAR_VAL(8'h5A)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .init_busy (init_busy),
    .a_en      (a_en),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_rdata   (a_rdata),
    .a_rvalid  (a_rvalid),
    .b_en      (b_en),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_rdata   (b_rdata),
    .b_rvalid  (b_rvalid),
    .wr_coll   (wr_coll)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_en = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_en = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
  endtask

  task automatic wr(input bit port_b, input logic [3:0] addr, input logic [7:0] data);
    if (port_b) begin b_en = 1'b1; b_we = 1'b1; b_addr = addr; b_wdata = data; end
    else        begin a_en = 1'b1; a_we = 1'b1; a_addr = addr; a_wdata = data; end
    step();
    idle();
  endtask

  // Single read, checks latency, data and that rvalid is a one-cycle pulse
  task automatic rd(input bit port_b, input logic [3:0] addr, input logic [7:0] exp, input string tag);
    if (port_b) begin b_en = 1'b1; b_we = 1'b0; b_addr = addr; end
    else        begin a_en = 1'b1; a_we = 1'b0; a_addr = addr; end
    step();
    idle();
    for (int k = 1; k < LAT; k++) begin
      chk({tag, "_early_rvalid"}, port_b ? b_rvalid : a_rvalid, 1'b0);
      step();
    end
    chk({tag, "_rvalid"}, port_b ? b_rvalid : a_rvalid, 1'b1);
    chk({tag, "_rdata"}, port_b ? b_rdata : a_rdata, exp);
    step();
    chk({tag, "_rvalid_pulse"}, port_b ? b_rvalid : a_rvalid, 1'b0);
    chk({tag, "_rdata_hold"}, port_b ? b_rdata : a_rdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_busy", init_busy, 1'b1);
    chk("rst_a_rdata", a_rdata, 8'h00);
    chk("rst_b_rdata", b_rdata, 8'h00);
    chk("rst_a_rvalid", a_rvalid, 1'b0);
    chk("rst_b_rvalid", b_rvalid, 1'b0);
    chk("rst_wr_coll", wr_coll, 1'b0);

    // Clear window with requests on both ports: writes to addr 1, then reads
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 8) begin
        a_en = 1'b1; a_we = 1'b1; a_addr = 4'd1; a_wdata = 8'hAA;
        b_en = 1'b1; b_we = 1'b1; b_addr = 4'd1; b_wdata = 8'hBB;
      end else begin
        a_en = 1'b1; a_we = 1'b0; a_addr = 4'd1;
        b_en = 1'b1; b_we = 1'b0; b_addr = 4'd14;
      end
      step();
      chk($sformatf("clr_busy_%0d", i), init_busy, (i < 15) ? 1'b1 : 1'b0);
      chk($sformatf("clr_a_rvalid_%0d", i), a_rvalid, 1'b0);
      chk($sformatf("clr_b_rvalid_%0d", i), b_rvalid, 1'b0);
      chk($sformatf("clr_wr_coll_%0d", i), wr_coll, 1'b0);
    end
    idle();

    // Every address holds CLEAR_VAL
    for (int i = 0; i < 16; i++) rd(1'b0, 4'(i), 8'h5A, $sformatf("clrval_%0d", i));

    // Back-to-back reads on both ports, one per cycle
    for (int i = 0; i < 15 + LAT; i++) begin
      if (i < 16) begin
        a_en = 1'b1; a_we = 1'b0; a_addr = 4'(i);
        b_en = 1'b1; b_we = 1'b0; b_addr = 4'(15 - i);
      end else idle();
      step();
      if (i >= LAT - 1) begin
        chk($sformatf("burst_a_rvalid_%0d", i), a_rvalid, 1'b1);
        chk($sformatf("burst_a_rdata_%0d", i), a_rdata, 8'h5A);
        chk($sformatf("burst_b_rvalid_%0d", i), b_rvalid, 1'b1);
        chk($sformatf("burst_b_rdata_%0d", i), b_rdata, 8'h5A);
      end
    end
    idle();
    step();
    chk("burst_a_end", a_rvalid, 1'b0);
    chk("burst_b_end", b_rvalid, 1'b0);

    // A writes 3C to addr 3, B reads it the next cycle
    wr(1'b0, 4'd3, 8'h3C);
    chk("wr_no_rvalid", a_rvalid, 1'b0);
    chk("wr_rdata_hold", a_rdata, 8'h5A);
    rd(1'b1, 4'd3, 8'h3C, "b_rd3");

    // Write/write collision at addr 7
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd7; a_wdata = 8'h11;
    b_en = 1'b1; b_we = 1'b1; b_addr = 4'd7; b_wdata = 8'h22;
    step();
    idle();
    chk("coll_pulse", wr_coll, 1'b1);
    step();
    chk("coll_end", wr_coll, 1'b0);
    rd(1'b0, 4'd7, 8'h11, "coll_a_rd7");
    rd(1'b1, 4'd7, 8'h11, "coll_b_rd7");

    // Different-address double write: no collision
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd8; a_wdata = 8'h81;
    b_en = 1'b1; b_we = 1'b1; b_addr = 4'd9; b_wdata = 8'h92;
    step();
    idle();
    chk("nocoll", wr_coll, 1'b0);
    rd(1'b0, 4'd9, 8'h92, "nocoll_rd9");
    rd(1'b1, 4'd8, 8'h81, "nocoll_rd8");

    // Read-first: A writes FF to addr 2 while B reads addr 2
    a_en = 1'b1; a_we = 1'b1; a_addr = 4'd2; a_wdata = 8'hFF;
    b_en = 1'b1; b_we = 1'b0; b_addr = 4'd2;
    step();
    idle();
    for (int k = 1; k < LAT; k++) step();
    chk("rfw_b_rvalid", b_rvalid, 1'b1);
    chk("rfw_b_rdata", b_rdata, 8'h5A);
    chk("rfw_a_rvalid", a_rvalid, 1'b0);
    step();
    rd(1'b1, 4'd2, 8'hFF, "rfw_after");

    // Top address and address 0, clear-time writes to addr 1 were dropped
    wr(1'b1, 4'd15, 8'h96);
    wr(1'b0, 4'd0, 8'h01);
    rd(1'b0, 4'd15, 8'h96, "rd15");
    rd(1'b0, 4'd0, 8'h01, "rd0");
    rd(1'b1, 4'd1, 8'h5A, "rd1_clr_drop");

    // Reset from RUN: outputs clear immediately
    rst_n = 1'b0;
    #1;
    chk("rrun_busy", init_busy, 1'b1);
    chk("rrun_a_rdata", a_rdata, 8'h00);
    chk("rrun_b_rdata", b_rdata, 8'h00);
    chk("rrun_wr_coll", wr_coll, 1'b0);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      chk($sformatf("part_busy_%0d", i), init_busy, 1'b1);
    end

    // Reset at clear cycle 9: clear restarts from 0 and runs a full 16 cycles
    rst_n = 1'b0;
    #1;
    chk("rclr_busy", init_busy, 1'b1);
    chk("rclr_a_rvalid", a_rvalid, 1'b0);
    chk("rclr_a_rdata", a_rdata, 8'h00);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step();
      chk($sformatf("reclr_busy_%0d", i), init_busy, (i < 15) ? 1'b1 : 1'b0);
      chk($sformatf("reclr_a_rvalid_%0d", i), a_rvalid, 1'b0);
    end
    rd(1'b0, 4'd0, 8'h5A, "reclr_rd0");
    rd(1'b1, 4'd15, 8'h5A, "reclr_rd15");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdp_ram.md
# tdp_ram

Parametrised true dual-port synchronous RAM, the successor to the fixed 16x8 dual-port store. It adds configurable width and depth, a post-reset clear sequencer, per-port read-valid strobes, defined same-address collision handling and an optional output pipeline stage. It sits between two independent masters (typically a loader and a consumer) that share one clock domain.

## Interface
- DATA_W, 8, data width per word (1..64)
- ADDR_W, 4, address width; depth is 2**ADDR_W words
- CLEAR_VAL, 0, value written to every word by the clear sequencer (DATA_W bits)
- clk  in  1  rising-edge clock for all logic
- rst_n  in  1  reset, asynchronous assert, active-low
- init_busy  out  1  high while the clear sequencer runs; ports are ignored
- a_en  in  1  port A access request
- a_we  in  1  port A write (1) / read (0); qualified by a_en
- a_addr  in  ADDR_W  port A address
- a_wdata  in  DATA_W  port A write data
- a_rdata  out  DATA_W  port A read data
- a_rvalid  out  1  one-cycle strobe: a_rdata holds new read data
- b_en, b_we, b_addr, b_wdata, b_rdata, b_rvalid: same as port A, for port B
- wr_coll  out  1  one-cycle strobe: both ports wrote the same address in one cycle

## Operation
- Reset values: init_busy=1, a_rdata=b_rdata=0, a_rvalid=b_rvalid=0, wr_coll=0, clear counter=0.
- The FSM has three states: CLEAR, RUN and REARM (REARM is reserved, never entered; it decodes to CLEAR).
- CLEAR:
  - writes CLEAR_VAL to address `cnt` each cycle; cnt increments by 1.
  - At cnt = 2**ADDR_W-1 the write happens, then the FSM goes to RUN and init_busy drops the next cycle.
  - Exactly 2**ADDR_W cycles are spent in CLEAR.
- In CLEAR, port requests are dropped: no write, no rvalid, no wr_coll.
- RUN, per port:
  - en=1, we=1: write wdata to addr. rdata is unchanged and rvalid=0.
  - en=1, we=0: read addr. rdata is updated and rvalid=1 after the latency below.
  - en=0: rdata holds and rvalid=0.
- Read-during-write across ports at the same address is read-first: the reader gets the old contents.
- Write/write collision at the same address: port A data is stored, port B data is discarded, and wr_coll pulses.
- Address wrap: counter arithmetic is modulo 2**ADDR_W; there is no out-of-range address.
- Reset asserted mid-CLEAR or mid-RUN:
  - outputs return to reset values immediately.
  - the clear restarts from address 0.
  - memory contents are not reset asynchronously; the clear sequencer is the only reset mechanism.

## Timing
- Read latency, without the output stage: request at edge N, rdata/rvalid valid after edge N+1.
- Read latency, with the output stage: valid after edge N+2.
- Reads are fully pipelined: one request per cycle per port, with no stalls in RUN.
- wr_coll is registered and asserts after the edge that performed the colliding write.
- init_busy falls exactly 2**ADDR_W cycles after rst_n deasserts. The first accepted request is in the cycle init_busy is low.
- rvalid never asserts while init_busy=1, nor in the first cycle after rst_n deassertion.

## Configuration
- TDP_RAM_OUT_REG_EN
  - Defined: an extra register stage follows the RAM read on both ports. rdata and rvalid move together through it, and read latency is 2 cycles.
  - Undefined: rdata/rvalid come straight from the RAM read register, and read latency is 1 cycle.
  - wr_coll and init_busy timing are identical in both builds.

## Structure
- Package tdp_ram_pkg holds:
  - typedef tdp_state_t (CLEAR, RUN, REARM)
  - localparam READ_LAT_BASE=1
  - the collision-priority constant PRIO_A=1
- Sub-module tdp_ram_port: one instance per port. It contains the read register, the optional output stage, and rvalid generation.
- The top level owns the memory array, the write arbitration and the clear FSM.

## Test plan
- Reset release, DATA_W=8, ADDR_W=4, CLEAR_VAL=8'h5A -> init_busy high for 16 cycles; then a read of every address returns 8'h5A, and a_rvalid pulses once per read.
- A writes 8'h3C to addr 3; next cycle B reads addr 3 -> b_rdata=8'h3C, with b_rvalid after 1 cycle (2 cycles with TDP_RAM_OUT_REG_EN).
- Same cycle, A writes 8'h11 and B writes 8'h22 to addr 7 -> wr_coll pulses once; a later read of addr 7 returns 8'h11.
- Same cycle, A writes 8'hFF to addr 2 and B reads addr 2 (old value 8'h5A) -> b_rdata=8'h5A; the next B read returns 8'hFF.
- Requests on both ports during CLEAR -> no rvalid, no wr_coll, and contents remain CLEAR_VAL after init_busy falls.
- rst_n pulsed low at clear cycle 9 -> outputs go to reset values at once; init_busy stays high for a full 16 cycles after release.
